// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkinvdiv.sv
// Multi-channel registered clock divider/inverter; ratio, polarity and enable apply only at period boundaries.
// Optional GF180MCU_CLKDIV_ALIGN_EN adds an ALIGN input that forces every channel to a common boundary.
module gf180mcu_fd_sc_mcu7t5v0__clkinvdiv #(
   parameter int CH = 4,
   parameter int DW = 4
) (
   input  logic             CLK,
   input  logic             RN,
   inout  wire              VDD,
   inout  wire              VSS,
`ifdef GF180MCU_CLKDIV_ALIGN_EN
   input  logic             ALIGN,
`endif
   input  logic [CH-1:0]    EN,
   input  logic [CH-1:0]    INV,
   input  logic [CH*DW-1:0] DIV,
   output logic [CH-1:0]    ZN,
   output logic [CH-1:0]    RISE
);

   logic [CH-1:0][DW-1:0] cnt_q, cnt_d;
   logic [CH-1:0][DW-1:0] div_q, div_d;
   logic [CH-1:0]         ph_q, ph_d;
   logic [CH-1:0]         inv_q, inv_d;
   logic [CH-1:0]         en_q, en_d;
   logic [CH-1:0]         zn_q, zn_d;
   logic [CH-1:0]         rise_q, rise_d;
   logic [CH-1:0]         load;
   logic                  align;
   wire                   unused_supply;

   assign unused_supply = VDD ^ VSS;

`ifdef GF180MCU_CLKDIV_ALIGN_EN
   assign align = ALIGN;
`else
   assign align = 1'b0;
`endif

   always_comb begin
      cnt_d  = cnt_q;
      div_d  = div_q;
      ph_d   = ph_q;
      inv_d  = inv_q;
      en_d   = en_q;
      load   = '0;
      zn_d   = '0;
      rise_d = '0;
      for (int c = 0; c < CH; c++) begin
         if (align || !en_q[c]) begin
            cnt_d[c] = '0;
            ph_d[c]  = 1'b0;
            load[c]  = 1'b1;
         end else if (cnt_q[c] == div_q[c]) begin
            cnt_d[c] = '0;
            ph_d[c]  = ~ph_q[c];
            // falling phase edge closes a full period: the only safe reload point
            load[c]  = ph_q[c];
         end else begin
            cnt_d[c] = cnt_q[c] + DW'(1);
         end
         if (load[c]) begin
            div_d[c] = DIV[c*DW +: DW];
            inv_d[c] = INV[c];
            en_d[c]  = EN[c];
         end
         zn_d[c]   = ph_d[c] ^ inv_d[c];
         rise_d[c] = ph_d[c] & ~ph_q[c];
      end
   end

   always_ff @(posedge CLK) begin
      if (!RN) begin
         cnt_q  <= '0;
         div_q  <= '0;
         ph_q   <= '0;
         inv_q  <= '0;
         en_q   <= '0;
         zn_q   <= '0;
         rise_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         div_q  <= div_d;
         ph_q   <= ph_d;
         inv_q  <= inv_d;
         en_q   <= en_d;
         zn_q   <= zn_d;
         rise_q <= rise_d;
      end
   end

   assign ZN   = zn_q;
   assign RISE = rise_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__clkinvdiv.sv
// Directed self-checking bench for the clock divider/inverter; ALIGN scenario built when GF180MCU_CLKDIV_ALIGN_EN is defined.
module tb_gf180mcu_fd_sc_mcu7t5v0__clkinvdiv;

   logic        clk = 1'b0;
   logic        rn;
   logic [3:0]  en;
   logic [3:0]  inv;
   logic [15:0] div;
   logic [3:0]  zn;
   logic [3:0]  rise;
   wire         vdd = 1'b1;
   wire         vss = 1'b0;
`ifdef GF180MCU_CLKDIV_ALIGN_EN
   logic        align = 1'b0;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   gf180mcu_fd_sc_mcu7t5v0__clkinvdiv #(.CH(4), .DW(4)) dut (
      .CLK  (clk),
      .RN   (rn),
      .VDD  (vdd),
      .VSS  (vss),
`ifdef GF180MCU_CLKDIV_ALIGN_EN
      .ALIGN(align),
`endif
      .EN   (en),
      .INV  (inv),
      .DIV  (div),
      .ZN   (zn),
      .RISE (rise)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ideal phase of a channel with half-period h, j edges after the enabling edge
   function automatic logic ph_of(int j, int h);
      return ((j / h) % 2) == 1;
   endfunction

   function automatic logic rise_of(int j, int h);
      return (j >= h) && (((j - h) % (2 * h)) == 0);
   endfunction

   task automatic do_reset();
      rn = 1'b0;
      step();
      step();
   endtask

   task automatic test_reset();
      en  = 4'b1111;
      inv = 4'b0000;
      div = {4'd15, 4'd3, 4'd1, 4'd0};
      do_reset();
      n_checks++;
      if (zn !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_zn: got %b expected %b", zn, 4'b0000);
      end
      n_checks++;
      if (rise !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_rise: got %b expected %b", rise, 4'b0000);
      end
   endtask

   task automatic test_ratios();
      int h[4] = '{1, 2, 4, 16};
      logic [3:0] ez, er;
      rn = 1'b1;
      step();
      for (int j = 0; j < 70; j++) begin
         for (int c = 0; c < 4; c++) begin
            ez[c] = ph_of(j, h[c]);
            er[c] = rise_of(j, h[c]);
         end
         n_checks++;
         if (zn !== ez) begin
            n_fail++;
            $display("FAIL ratio_zn j=%0d: got %b expected %b", j, zn, ez);
         end
         n_checks++;
         if (rise !== er) begin
            n_fail++;
            $display("FAIL ratio_rise j=%0d: got %b expected %b", j, rise, er);
         end
         step();
      end
   endtask

   task automatic test_ratio_change();
      logic p, r;
      en  = 4'b1111;
      inv = 4'b0000;
      div = {4{4'd3}};
      do_reset();
      rn = 1'b1;
      step();
      for (int j = 0; j < 24; j++) begin
         if (j < 8) begin
            p = ph_of(j, 4);
            r = (j == 4);
         end else begin
            p = ((j - 8) % 2) == 1;
            r = (j >= 9) && (((j - 9) % 2) == 0);
         end
         n_checks++;
         if (zn !== {4{p}}) begin
            n_fail++;
            $display("FAIL ratio_change_zn j=%0d: got %b expected %b", j, zn, {4{p}});
         end
         n_checks++;
         if (rise !== {4{r}}) begin
            n_fail++;
            $display("FAIL ratio_change_rise j=%0d: got %b expected %b", j, rise, {4{r}});
         end
         if (j == 5) div = '0;
         step();
      end
   endtask

   task automatic test_mid_stop();
      logic p, r;
      en  = 4'b1111;
      inv = 4'b1111;
      div = {4{4'd3}};
      do_reset();
      rn = 1'b1;
      step();
      for (int j = 0; j < 24; j++) begin
         p = (j < 8) ? ~ph_of(j, 4) : 1'b1;
         r = (j == 4);
         n_checks++;
         if (zn !== {4{p}}) begin
            n_fail++;
            $display("FAIL mid_stop_zn j=%0d: got %b expected %b", j, zn, {4{p}});
         end
         n_checks++;
         if (rise !== {4{r}}) begin
            n_fail++;
            $display("FAIL mid_stop_rise j=%0d: got %b expected %b", j, rise, {4{r}});
         end
         if (j == 6) en = 4'b0000;
         step();
      end
   endtask

   task automatic test_reset_mid();
      logic [3:0] ez, er;
      en  = 4'b1111;
      inv = 4'b0000;
      div = {4{4'd3}};
      do_reset();
      rn = 1'b1;
      step();
      for (int j = 0; j < 5; j++) step();
      n_checks++;
      if (zn !== 4'b1111) begin
         n_fail++;
         $display("FAIL reset_mid_pre_zn: got %b expected %b", zn, 4'b1111);
      end
      rn  = 1'b0;
      inv = 4'b1010;
      step();
      n_checks++;
      if (zn !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_mid_zn: got %b expected %b", zn, 4'b0000);
      end
      n_checks++;
      if (rise !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_mid_rise: got %b expected %b", rise, 4'b0000);
      end
      rn  = 1'b1;
      div = {4'd2, 4'd1, 4'd2, 4'd1};
      step();
      for (int j = 0; j < 12; j++) begin
         for (int c = 0; c < 4; c++) begin
            ez[c] = ph_of(j, (c % 2 == 0) ? 2 : 3) ^ inv[c];
            er[c] = rise_of(j, (c % 2 == 0) ? 2 : 3);
         end
         n_checks++;
         if (zn !== ez) begin
            n_fail++;
            $display("FAIL reset_mid_restart_zn j=%0d: got %b expected %b", j, zn, ez);
         end
         n_checks++;
         if (rise !== er) begin
            n_fail++;
            $display("FAIL reset_mid_restart_rise j=%0d: got %b expected %b", j, rise, er);
         end
         step();
      end
   endtask

`ifdef GF180MCU_CLKDIV_ALIGN_EN
   task automatic test_align();
      logic [3:0] ez, er;
      en  = 4'b1111;
      inv = 4'b0000;
      div = {4'd2, 4'd1, 4'd2, 4'd1};
      do_reset();
      rn = 1'b1;
      for (int j = 0; j < 8; j++) step();
      align = 1'b1;
      inv   = 4'b0110;
      step();
      align = 1'b0;
      for (int j = 0; j < 10; j++) begin
         for (int c = 0; c < 4; c++) begin
            ez[c] = ph_of(j, (c % 2 == 0) ? 2 : 3) ^ inv[c];
            er[c] = rise_of(j, (c % 2 == 0) ? 2 : 3);
         end
         n_checks++;
         if (zn !== ez) begin
            n_fail++;
            $display("FAIL align_zn j=%0d: got %b expected %b", j, zn, ez);
         end
         n_checks++;
         if (rise !== er) begin
            n_fail++;
            $display("FAIL align_rise j=%0d: got %b expected %b", j, rise, er);
         end
         step();
      end
   endtask
`endif

   initial begin
      rn  = 1'b0;
      en  = '0;
      inv = '0;
      div = '0;
      test_reset();
      test_ratios();
      test_ratio_change();
      test_mid_stop();
      test_reset_mid();
`ifdef GF180MCU_CLKDIV_ALIGN_EN
      test_align();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
